// File: rtl/approx_add_pkg.sv
// approx_add_pkg
//   Shared types and helpers for the pipelined approximate adder.
//   - mode_e    : run-time approximation mode carried with each input beat
//   - err_width : width of the signed error sum - exact (W+2 bits)
//   - sat_add   : saturating add used by all statistics counters
package approx_add_pkg;

   typedef enum logic [1:0] {
      EXACT    = 2'd0,
      NAND_LSB = 2'd1,
      LOA      = 2'd2,
      RSVD     = 2'd3
   } mode_e;

   // Signed error of two W+1-bit signed sums needs one extra bit.
   function automatic int err_width(input int w);
      return w + 2;
   endfunction

   // Adds inc to acc and clamps at max_val. Operands are zero-extended
   // 64-bit values, so any counter up to 63 bits wide is handled without
   // the intermediate sum wrapping.
   function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                           input logic [63:0] inc,
                                           input logic [63:0] max_val);
      logic [64:0] total;
      total = {1'b0, acc} + {1'b0, inc};
      if (total > {1'b0, max_val}) begin
         return max_val;
      end
      return total[63:0];
   endfunction

endpackage

// File: rtl/approx_add_stats.sv
// approx_add_stats
//   Error statistics for the approximate adder, updated on every output
//   transfer. All counters saturate at all-ones.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     xfer         output beat transferred this cycle
//     clr_stats    synchronous clear of all statistics; wins over xfer
//     sum          approximate sum of the transferring beat (signed)
//     exact        exact sum of the transferring beat (signed)
//     beat_cnt     transferred beats
//     err_cnt      beats where sum != exact
//     err_abs_sum  accumulated |sum - exact|
//     err_max      largest |sum - exact| seen
//   CNT_W + W must not exceed 63 (limit of the shared saturating adder).
module approx_add_stats
   import approx_add_pkg::*;
#(
   parameter int W     = 16,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               xfer,
   input  logic               clr_stats,
   input  logic [W:0]         sum,
   input  logic [W:0]         exact,
   output logic [CNT_W-1:0]   beat_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [CNT_W+W-1:0] err_abs_sum,
   output logic [W:0]         err_max
);

   localparam int EW = err_width(W);
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;
   localparam logic [CNT_W+W-1:0] ABS_MAX = '1;

   logic [EW-1:0] err;
   logic [W:0]    err_mag;

   // Both sums are W+1-bit signed; sign-extend once more before subtracting.
   assign err = {sum[W], sum} - {exact[W], exact};

   // |err| always fits W+1 bits, so the top bit only serves as the sign.
   assign err_mag = err[EW-1] ? (~err[W:0] + {{W{1'b0}}, 1'b1}) : err[W:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt    <= '0;
         err_cnt     <= '0;
         err_abs_sum <= '0;
         err_max     <= '0;
      end else if (clr_stats) begin
         beat_cnt    <= '0;
         err_cnt     <= '0;
         err_abs_sum <= '0;
         err_max     <= '0;
      end else if (xfer) begin
         beat_cnt    <= CNT_W'(sat_add(64'(beat_cnt), 64'd1, 64'(CNT_MAX)));
         if (err != '0) begin
            err_cnt  <= CNT_W'(sat_add(64'(err_cnt), 64'd1, 64'(CNT_MAX)));
         end
         err_abs_sum <= (CNT_W+W)'(sat_add(64'(err_abs_sum), 64'(err_mag),
                                           64'(ABS_MAX)));
         if (err_mag > err_max) begin
            err_max  <= err_mag;
         end
      end
   end

endmodule

// File: rtl/approx_add_pipe.sv
// approx_add_pipe
//   Pipelined signed approximate adder with an exact reference sum carried
//   alongside and live error statistics.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid, in_ready      input handshake
//     a, b                    W-bit signed operands
//     mode                    approximation mode (approx_add_pkg::mode_e)
//     out_valid, out_ready    output handshake
//     sum                     W+1-bit signed approximate sum
//     clr_stats               synchronous clear of the statistics
//     beat_cnt, err_cnt,
//     err_abs_sum, err_max    error statistics (see approx_add_stats)
//
//   Handshake: a beat moves on a rising edge when valid && ready. The whole
//   pipeline shares one enable en = !out_valid || out_ready; in_ready = en,
//   so a stalled output freezes every stage (bubbles are kept, not
//   collapsed) and sum/out_valid hold steady until out_ready rises.
//
//   The W+1-bit carry chain is cut into STAGES segments of ceil(W/STAGES)
//   bits; stage s resolves segment s for both the approximate and the exact
//   sum, and the carry out of each segment is registered for the next one.
module approx_add_pipe
   import approx_add_pkg::*;
#(
   parameter int W      = 16,
   parameter int K      = 1,
   parameter int STAGES = 2,
   parameter int CNT_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       a,
   input  logic [W-1:0]       b,
   input  logic [1:0]         mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W:0]         sum,
   input  logic               clr_stats,
   output logic [CNT_W-1:0]   beat_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [CNT_W+W-1:0] err_abs_sum,
   output logic [W:0]         err_max
);

   localparam int N   = W + 1;
   localparam int SEG = (W + STAGES - 1) / STAGES;

   // Ripple one segment [lo, hi] of the chain. Bits flagged in fix carry a
   // precomputed result in p and force their carry-out to g; this is how
   // the approximate LSBs inject their own carry into bit K.
   function automatic logic [N:0] seg_add(input logic [N-1:0] p,
                                          input logic [N-1:0] g,
                                          input logic [N-1:0] fix,
                                          input logic [N-1:0] acc,
                                          input logic         cin,
                                          input int           lo,
                                          input int           hi);
      logic         c;
      logic [N-1:0] r;
      c = cin;
      r = acc;
      for (int i = 0; i < N; i++) begin
         if (i >= lo && i <= hi) begin
            r[i] = fix[i] ? p[i] : (p[i] ^ c);
            c    = fix[i] ? g[i] : (g[i] | (p[i] & c));
         end
      end
      return {c, r};
   endfunction

   logic          en;
   mode_e         mode_sel;
   logic [N-1:0]  a_ext, b_ext;
   logic [N-1:0]  ap0, ag0, afix0;
   logic          cin0;

   // Per-stage inputs (i_*), combinational results (d_*), registers (q_*).
   logic          i_v    [STAGES];
   logic [N-1:0]  i_ap   [STAGES];
   logic [N-1:0]  i_ag   [STAGES];
   logic [N-1:0]  i_afix [STAGES];
   logic [N-1:0]  i_ep   [STAGES];
   logic [N-1:0]  i_eg   [STAGES];
   logic [N-1:0]  i_asum [STAGES];
   logic [N-1:0]  i_esum [STAGES];
   logic          i_ac   [STAGES];
   logic          i_ec   [STAGES];

   logic [N-1:0]  d_asum [STAGES];
   logic [N-1:0]  d_esum [STAGES];
   logic          d_ac   [STAGES];
   logic          d_ec   [STAGES];

   logic          q_v    [STAGES];
   logic [N-1:0]  q_ap   [STAGES];
   logic [N-1:0]  q_ag   [STAGES];
   logic [N-1:0]  q_afix [STAGES];
   logic [N-1:0]  q_ep   [STAGES];
   logic [N-1:0]  q_eg   [STAGES];
   logic [N-1:0]  q_asum [STAGES];
   logic [N-1:0]  q_esum [STAGES];
   logic          q_ac   [STAGES];
   logic          q_ec   [STAGES];

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign mode_sel = mode_e'(mode);

   // Operand preparation: per-bit propagate/generate of the sign-extended
   // operands. In the approximate modes the low K bits are replaced by the
   // NAND/OR result and all of them generate the same carry, so only
   // a[K-1] & b[K-1] reaches bit K. RSVD falls through as exact.
   always_comb begin
      a_ext = {a[W-1], a};
      b_ext = {b[W-1], b};
      cin0  = a[K-1] & b[K-1];
      ap0   = a_ext ^ b_ext;
      ag0   = a_ext & b_ext;
      afix0 = '0;
      if (mode_sel == NAND_LSB || mode_sel == LOA) begin
         for (int i = 0; i < K; i++) begin
            afix0[i] = 1'b1;
            ap0[i]   = (mode_sel == NAND_LSB) ? ~(a[i] & b[i]) : (a[i] | b[i]);
            ag0[i]   = cin0;
         end
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = s * SEG;
      localparam int HI = (s == STAGES - 1) ? N - 1 : (s + 1) * SEG - 1;

      if (s == 0) begin : g_first
         assign i_v[s]    = in_valid;
         assign i_ap[s]   = ap0;
         assign i_ag[s]   = ag0;
         assign i_afix[s] = afix0;
         assign i_ep[s]   = a_ext ^ b_ext;
         assign i_eg[s]   = a_ext & b_ext;
         assign i_asum[s] = '0;
         assign i_esum[s] = '0;
         assign i_ac[s]   = 1'b0;
         assign i_ec[s]   = 1'b0;
      end else begin : g_next
         assign i_v[s]    = q_v[s-1];
         assign i_ap[s]   = q_ap[s-1];
         assign i_ag[s]   = q_ag[s-1];
         assign i_afix[s] = q_afix[s-1];
         assign i_ep[s]   = q_ep[s-1];
         assign i_eg[s]   = q_eg[s-1];
         assign i_asum[s] = q_asum[s-1];
         assign i_esum[s] = q_esum[s-1];
         assign i_ac[s]   = q_ac[s-1];
         assign i_ec[s]   = q_ec[s-1];
      end

      assign {d_ac[s], d_asum[s]} = seg_add(i_ap[s], i_ag[s], i_afix[s],
                                            i_asum[s], i_ac[s], LO, HI);
      assign {d_ec[s], d_esum[s]} = seg_add(i_ep[s], i_eg[s], '0,
                                            i_esum[s], i_ec[s], LO, HI);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            q_v[s]    <= 1'b0;
            q_ap[s]   <= '0;
            q_ag[s]   <= '0;
            q_afix[s] <= '0;
            q_ep[s]   <= '0;
            q_eg[s]   <= '0;
            q_asum[s] <= '0;
            q_esum[s] <= '0;
            q_ac[s]   <= 1'b0;
            q_ec[s]   <= 1'b0;
         end
      end else if (en) begin
         for (int s = 0; s < STAGES; s++) begin
            q_v[s]    <= i_v[s];
            q_ap[s]   <= i_ap[s];
            q_ag[s]   <= i_ag[s];
            q_afix[s] <= i_afix[s];
            q_ep[s]   <= i_ep[s];
            q_eg[s]   <= i_eg[s];
            q_asum[s] <= d_asum[s];
            q_esum[s] <= d_esum[s];
            q_ac[s]   <= d_ac[s];
            q_ec[s]   <= d_ec[s];
         end
      end
   end

   assign out_valid = q_v[STAGES-1];
   assign sum       = q_asum[STAGES-1];

   approx_add_stats #(
      .W     (W),
      .CNT_W (CNT_W)
   ) u_stats (
      .clk         (clk),
      .rst_n       (rst_n),
      .xfer        (out_valid && out_ready),
      .clr_stats   (clr_stats),
      .sum         (q_asum[STAGES-1]),
      .exact       (q_esum[STAGES-1]),
      .beat_cnt    (beat_cnt),
      .err_cnt     (err_cnt),
      .err_abs_sum (err_abs_sum),
      .err_max     (err_max)
   );

endmodule

// File: tb/tb_approx_add_pipe.sv
// tb_approx_add_pipe
//   Directed bench for approx_add_pipe. Two instances share clock and reset:
//   u_dut1 (W=16, K=1, STAGES=2, CNT_W=32) and u_dut2 (W=16, K=4, STAGES=3,
//   CNT_W=4, narrow counters to reach saturation quickly).
module tb_approx_add_pipe;

   localparam int W = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- dut1 ----------------
   logic          in_valid1, in_ready1, out_valid1, out_ready1, clr1;
   logic [W-1:0]  a1, b1;
   logic [1:0]    mode1;
   logic [W:0]    sum1, max1;
   logic [31:0]   beat1, errc1;
   logic [47:0]   abs1;

   // ---------------- dut2 ----------------
   logic          in_valid2, in_ready2, out_valid2, out_ready2, clr2;
   logic [W-1:0]  a2, b2;
   logic [1:0]    mode2;
   logic [W:0]    sum2, max2;
   logic [3:0]    beat2, errc2;
   logic [19:0]   abs2;

   approx_add_pipe #(.W(16), .K(1), .STAGES(2), .CNT_W(32)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .mode(mode1),
      .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
      .clr_stats(clr1), .beat_cnt(beat1), .err_cnt(errc1),
      .err_abs_sum(abs1), .err_max(max1)
   );

   approx_add_pipe #(.W(16), .K(4), .STAGES(3), .CNT_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .mode(mode2),
      .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
      .clr_stats(clr2), .beat_cnt(beat2), .err_cnt(errc2),
      .err_abs_sum(abs2), .err_max(max2)
   );

   // ---------------- scoreboard ----------------
   int         checks = 0;
   int         errors = 0;
   int         n_out1 = 0;
   logic [W:0] exp_q1[$];
   logic [W:0] exp_q2[$];
   logic [W:0] cur_exp1, cur_exp2;

   function automatic logic [W:0] s17(input int v);
      return v[W:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One clock: sample handshakes at the falling edge, score any output
   // transfer, queue the expected sum of any accepted input, then return
   // 1 time unit after the next rising edge.
   task automatic tick(output bit acc1, output bit acc2);
      @(negedge clk);
      acc1 = in_valid1 && in_ready1;
      acc2 = in_valid2 && in_ready2;
      if (out_valid1 && out_ready1) begin
         n_out1++;
         if (exp_q1.size() == 0) chk("dut1_spurious_out", 64'(out_valid1), 64'd0);
         else chk("dut1_sum", 64'(sum1), 64'(exp_q1.pop_front()));
      end
      if (out_valid2 && out_ready2) begin
         if (exp_q2.size() == 0) chk("dut2_spurious_out", 64'(out_valid2), 64'd0);
         else chk("dut2_sum", 64'(sum2), 64'(exp_q2.pop_front()));
      end
      if (acc1) exp_q1.push_back(cur_exp1);
      if (acc2) exp_q2.push_back(cur_exp2);
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      bit x1, x2;
      tick(x1, x2);
   endtask

   task automatic drive1(input int av, input int bv, input logic [1:0] m,
                         input int expv);
      in_valid1 = 1'b1;
      a1 = W'(av);
      b1 = W'(bv);
      mode1 = m;
      cur_exp1 = s17(expv);
   endtask

   task automatic drive2(input int av, input int bv, input logic [1:0] m,
                         input int expv);
      in_valid2 = 1'b1;
      a2 = W'(av);
      b2 = W'(bv);
      mode2 = m;
      cur_exp2 = s17(expv);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   int         va[8] = '{100, -200, 32767, -32768, 5, 12345, -1, 7};
   int         vb[8] = '{23, 50, 32767, -32768, -5, 1000, -1, 0};
   int         idx;
   int         base_out;
   bit         acc, acc_dummy;
   logic [W:0] held;

   initial begin
      rst_n = 1'b0;
      in_valid1 = 0; out_ready1 = 1; clr1 = 0; a1 = '0; b1 = '0; mode1 = '0;
      in_valid2 = 0; out_ready2 = 1; clr2 = 0; a2 = '0; b2 = '0; mode2 = '0;
      cur_exp1 = '0; cur_exp2 = '0;
      held = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk("rst_out_valid1", 64'(out_valid1), 64'd0);
      chk("rst_sum1",       64'(sum1),       64'd0);
      chk("rst_beat1",      64'(beat1),      64'd0);
      chk("rst_out_valid2", 64'(out_valid2), 64'd0);
      chk("rst_abs2",       64'(abs2),       64'd0);
      rst_n = 1'b1;
      step();
      chk("in_ready_after_rst", 64'(in_ready1), 64'd1);

      // Mode 0 latency: 20 + 10 = 30, two cycles after acceptance
      drive1(20, 10, 2'd0, 30);
      step();
      in_valid1 = 0;
      chk("lat_not_early", 64'(out_valid1), 64'd0);
      step();
      chk("lat_out_valid", 64'(out_valid1), 64'd1);
      chk("lat_sum",       64'(sum1),       64'(s17(30)));
      step();
      chk("exact_beat_cnt", 64'(beat1), 64'd1);
      chk("exact_err_cnt",  64'(errc1), 64'd0);
      chk("exact_err_max",  64'(max1),  64'd0);

      // Mode 1 (NAND LSB, K=1): 31, 27704, -5064 -> one error of magnitude 1
      clr1 = 1;
      step();
      clr1 = 0;
      chk("clr_beat1", 64'(beat1), 64'd0);
      drive1(20, 10, 2'd1, 31);            step();
      drive1(12831, 14873, 2'd1, 27704);   step();
      drive1(-19937, 14873, 2'd1, -5064);  step();
      in_valid1 = 0;
      repeat (4) step();
      chk("nand_q_empty",    64'(exp_q1.size()), 64'd0);
      chk("nand_beat_cnt",   64'(beat1), 64'd3);
      chk("nand_err_cnt",    64'(errc1), 64'd1);
      chk("nand_err_abs",    64'(abs1),  64'd1);
      chk("nand_err_max",    64'(max1),  64'd1);

      // Mode 3 (reserved) behaves as exact: no new error
      drive1(20, 10, 2'd3, 30);
      step();
      in_valid1 = 0;
      repeat (3) step();
      chk("rsvd_beat_cnt", 64'(beat1), 64'd4);
      chk("rsvd_err_cnt",  64'(errc1), 64'd1);

      // dut2, K=4, LOA: 15+1 -> 15 (e=-1); 8+8 -> 24 (e=+8)
      drive2(15, 1, 2'd2, 15);  step();
      drive2(8, 8, 2'd2, 24);   step();
      in_valid2 = 0;
      repeat (5) step();
      chk("loa_q_empty",  64'(exp_q2.size()), 64'd0);
      chk("loa_beat_cnt", 64'(beat2), 64'd2);
      chk("loa_err_cnt",  64'(errc2), 64'd2);
      chk("loa_err_abs",  64'(abs2),  64'd9);
      chk("loa_err_max",  64'(max2),  64'd8);

      // Continuous exact stream on dut1 with out_ready low for 3 cycles
      idx = 0;
      base_out = n_out1;
      for (int c = 0; c < 16; c++) begin
         out_ready1 = !(c >= 4 && c <= 6);
         if (idx < 8) drive1(va[idx], vb[idx], 2'd0, va[idx] + vb[idx]);
         else in_valid1 = 0;
         #1;
         if (c >= 4 && c <= 6) begin
            chk("stall_in_ready",  64'(in_ready1),  64'd0);
            chk("stall_out_valid", 64'(out_valid1), 64'd1);
            if (c == 4) held = sum1;
            else chk("stall_sum_hold", 64'(sum1), 64'(held));
         end
         tick(acc, acc_dummy);
         if (acc) idx++;
      end
      in_valid1 = 0;
      out_ready1 = 1;
      chk("stream_accepted", 64'(idx), 64'd8);
      chk("stream_delivered", 64'(n_out1 - base_out), 64'd8);
      chk("stream_q_empty", 64'(exp_q1.size()), 64'd0);

      // dut2 saturation: 17 erroneous beats on 4-bit counters
      clr2 = 1;
      step();
      clr2 = 0;
      drive2(8, 8, 2'd2, 24);
      repeat (17) step();
      in_valid2 = 0;
      repeat (5) step();
      chk("sat_q_empty",  64'(exp_q2.size()), 64'd0);
      chk("sat_err_cnt",  64'(errc2), 64'd15);
      chk("sat_beat_cnt", 64'(beat2), 64'd15);
      chk("sat_err_abs",  64'(abs2),  64'd136);
      chk("sat_err_max",  64'(max2),  64'd8);

      // clr_stats in the same cycle as a transfer: clear wins
      drive2(8, 8, 2'd2, 24);
      step();
      in_valid2 = 0;
      step();
      step();
      chk("clrx_out_valid", 64'(out_valid2), 64'd1);
      clr2 = 1;
      step();
      clr2 = 0;
      chk("clrx_beat_cnt", 64'(beat2), 64'd0);
      chk("clrx_err_cnt",  64'(errc2), 64'd0);
      chk("clrx_err_abs",  64'(abs2),  64'd0);
      chk("clrx_err_max",  64'(max2),  64'd0);

      // Reset mid-stream with two beats in flight on dut1
      drive1(1, 2, 2'd0, 3);  step();
      drive1(3, 4, 2'd0, 7);  step();
      in_valid1 = 0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid1), 64'd0);
      chk("midrst_sum",       64'(sum1),       64'd0);
      chk("midrst_beat_cnt",  64'(beat1),      64'd0);
      chk("midrst_err_abs",   64'(abs1),       64'd0);
      exp_q1.delete();
      exp_q2.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
         chk("postrst_out_valid", 64'(out_valid1), 64'd0);
         chk("postrst_in_ready",  64'(in_ready1),  64'd1);
         step();
      end
      chk("postrst_beat_cnt", 64'(beat1), 64'd0);
      chk("postrst_err_max",  64'(max1),  64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
